imem_loader: RTL and testbench

- Boot-time writer for the instruction memory, which the single-cycle core only reads.
- Accepts a byte stream over a valid/ready handshake and packs the bytes into 32-bit little-endian words.
- Writes the words to consecutive word addresses through a synchronous write port.
- Holds the core in reset until the image is fully loaded, replacing $readmemh preloading in hardware builds.

---
 rtl/imem_loader_if.sv | 57 +++++
 rtl/imem_loader.sv | 145 ++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream and instruction-memory write bundle used by
//               imem_loader. The master side drives the byte stream and
//               observes the write port and status; the slave side is the
//               loader itself.
//               Signals:
//                 in_valid/in_data/in_last -> byte stream into the loader
//                 in_ready                 <- loader can accept a byte
//                 we/waddr/wdata           <- instruction-memory write port
//                 core_reset/done/err      <- boot status
//                 word_count               <- words written so far
//                 checksum                 <- sum of written words
//                                             (IMEM_LOADER_CHECKSUM_EN only)
// Optional    : IMEM_LOADER_CHECKSUM_EN adds the checksum signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          core_reset;
  logic          done;
  logic          err;
  logic [AW:0]   word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   checksum;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, we, waddr, wdata, core_reset, done, err, word_count,
           checksum
  );
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, we, waddr, wdata, core_reset, done, err, word_count,
           checksum
  );
`else
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, we, waddr, wdata, core_reset, done, err, word_count
  );
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, we, waddr, wdata, core_reset, done, err, word_count
  );
`endif
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction-memory writer. Packs a byte stream
//               (valid/ready) into 32-bit little-endian words, writes them to
//               consecutive word addresses and holds the core in reset until
//               the whole image is loaded.
//               Ports:
//                 clk    - system clock, rising edge
//                 reset  - asynchronous, active-low reset
//                 bus    - imem_loader_if.slave: byte stream in, write port,
//                          core_reset/done/err status and word_count out
// Parameters  : DEPTH - memory size in words (must equal 2**AW)
//               AW    - word-address width
// Optional    : IMEM_LOADER_CHECKSUM_EN adds a running 32-bit sum of all
//               written words on bus.checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  wire logic    clk,
  input  wire logic    reset,
  imem_loader_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;

  logic        xfer;
  logic        complete;
  logic [31:0] word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      lane_q  <= 2'd0;
      cnt_q   <= '0;
      asm_q   <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    xfer     = bus.in_valid & ready_q;
    // Earlier lanes already sit in asm_q; upper lanes are still zero there.
    word     = asm_q | ({24'd0, bus.in_data} << {lane_q, 3'b000});
    complete = xfer & ((lane_q == 2'd3) | bus.in_last);

    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    // The pointer advances on the edge that ends the write cycle.
    cnt_d   = cnt_q + {{AW{1'b0}}, we_q};

    unique case (state_q)
      S_LOAD: begin
        if (xfer) begin
          if (complete) begin
            lane_d = 2'd0;
            asm_d  = 32'd0;
            // A short in_last word can complete while the previous word's
            // write is still in flight, so judge fullness on the count as it
            // will stand after that write.
            if (cnt_d == FULL_CNT) begin
              state_d = S_ERROR;
            end else begin
              we_d    = 1'b1;
              wdata_d = word;
              if (bus.in_last) begin
                state_d = S_FLUSH;
              end
            end
          end else begin
            lane_d = lane_q + 2'd1;
            asm_d  = word;
          end
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: ; // DONE and ERROR hold until reset
    endcase

    ready_d = (state_d == S_LOAD);
  end

  assign bus.in_ready   = ready_q;
  assign bus.we         = we_q;
  assign bus.waddr      = cnt_q[AW-1:0];
  assign bus.wdata      = wdata_q;
  assign bus.core_reset = (state_q != S_DONE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.err        = (state_q == S_ERROR);
  assign bus.word_count = cnt_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (we_q) begin
      sum_d = sum_q + wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= 32'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign bus.checksum = sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Byte images are fed
//               with back-to-back, toggling or random valid gaps; expected
//               memory words, counts and status are computed from the byte
//               image with plain arithmetic and compared against the writes
//               captured from the DUT write port.
// Optional    : IMEM_LOADER_CHECKSUM_EN enables checksum comparisons.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_loader_if #(.AW(AW)) bus ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  img_q[$];
  int unsigned wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every issued write, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.we === 1'b1) begin
      wr_addr_q.push_back(int'(bus.waddr));
      wr_data_q.push_back(bus.wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Asserts reset mid-cycle and checks the asynchronous clear before any edge.
  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'd0;
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready",   bus.in_ready,   0);
    chk("rst_we",         bus.we,         0);
    chk("rst_waddr",      bus.waddr,      0);
    chk("rst_wdata",      bus.wdata,      0);
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_done",       bus.done,       0);
    chk("rst_err",        bus.err,        0);
    chk("rst_word_count", bus.word_count, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("rst_checksum",   bus.checksum,   0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offers one byte after 'idle' idle cycles; returns #1 after the transfer edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input int idle,
                           input logic chk_ready);
    int budget;
    for (int i = 0; i < idle; i++) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      @(posedge clk);
      #1;
      if (chk_ready) chk("ready_in_idle", bus.in_ready, 1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 50) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 50) begin
      chk("ready_timeout", bus.in_ready, 1);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode: 0 back-to-back, 1 valid toggling, 2 random gaps.
  task automatic run_image(input string name, input int mode, input logic use_last,
                           input logic do_reset);
    int          n, nw, nexp, idle, idx;
    logic        ovf, exp_done;
    logic [31:0] w, sum;
    logic [AW:0] cnt_snap;
    if (do_reset) apply_reset();
    wr_addr_q.delete();
    wr_data_q.delete();
    n = img_q.size();
    for (int i = 0; i < n; i++) begin
      if (mode == 0)      idle = 0;
      else if (mode == 1) idle = (i == 0) ? 0 : 1;
      else                idle = $urandom_range(0, 2);
      send_byte(img_q[i], use_last && (i == n - 1), idle, mode == 1);
    end
    nw       = (n + 3) / 4;
    ovf      = (nw > DEPTH);
    nexp     = ovf ? DEPTH : nw;
    exp_done = use_last && !ovf;
    if (exp_done) begin
      // Cycle after the final transfer carries the last write.
      chk({name, ":flush_we"},         bus.we,         1);
      chk({name, ":flush_done"},       bus.done,       0);
      chk({name, ":flush_core_reset"}, bus.core_reset, 1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    #1;
    chk({name, ":done"},       bus.done,       exp_done);
    chk({name, ":core_reset"}, bus.core_reset, !exp_done);
    chk({name, ":err"},        bus.err,        ovf);
    chk({name, ":word_count"}, bus.word_count, nexp);
    chk({name, ":n_writes"},   wr_addr_q.size(), nexp);
    sum = 32'd0;
    for (int k = 0; k < nexp; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        idx = 4 * k + b;
        if (idx < n) w = w | ({24'd0, img_q[idx]} << (8 * b));
      end
      sum = sum + w;
      if (k < wr_addr_q.size()) begin
        chk({name, ":waddr"}, wr_addr_q[k], k);
        chk({name, ":wdata"}, wr_data_q[k], w);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (exp_done) chk({name, ":checksum"}, bus.checksum, sum);
`endif
    // Terminal state: further bytes are refused and nothing is written.
    cnt_snap = bus.word_count;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'($urandom);
      bus.in_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk({name, ":post_ready"},  bus.in_ready,     0);
    chk({name, ":post_count"},  bus.word_count,   cnt_snap);
    chk({name, ":post_writes"}, wr_addr_q.size(), nexp);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = 8'd0;
    @(posedge clk);
    #1;

    // Two RISC-V instructions, streamed back-to-back.
    img_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_image("prog", 0, 1'b1, 1'b1);
    if (wr_data_q.size() == 2) begin
      chk("prog:word0_lit", wr_data_q[0], 32'h0000_0513);
      chk("prog:word1_lit", wr_data_q[1], 32'h0010_0593);
    end else begin
      chk("prog:write_count_lit", wr_data_q.size(), 2);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("prog:checksum_lit", bus.checksum, 32'h0010_0AA6);
`endif

    // Partial final word right after a full word.
    img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
    run_image("partial", 0, 1'b1, 1'b1);

    // Same program with in_valid toggling every cycle.
    img_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    run_image("toggle", 1, 1'b1, 1'b1);

    // Overflow: 257 words with no in_last.
    img_q.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) img_q.push_back(8'($urandom));
    run_image("overflow", 0, 1'b0, 1'b1);

    // Reset after six bytes, then a fresh four-byte image.
    apply_reset();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, 0, 1'b0);
    img_q = '{8'h5A, 8'hC3, 8'h7E, 8'h01};
    run_image("midreset", 0, 1'b1, 1'b1);
    chk("midreset:addr0", (wr_addr_q.size() == 1) ? wr_addr_q[0] : 32'hFFFF_FFFF, 0);

    // Random images with random gaps and random single-byte tails.
    for (int t = 0; t < 8; t++) begin
      img_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) img_q.push_back(8'($urandom));
      run_image("random", int'($urandom_range(0, 2)), 1'b1, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
